// File: rtl/s_cska_pkg.sv
// Shared types for the s_cska accumulator stage: FSM state encoding and the
// width helper used to size the sample counter.
package s_cska_pkg;

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_e;

   // Ceiling log2; callers apply their own minimum width.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/s_cska_acc_add.sv
// Combinational signed accumulate step with overflow detect.
// Build option S_CSKA_ACC_SAT_EN: clamp on overflow instead of wrapping.
module s_cska_acc_add #(
   parameter int ACC_W = 12
) (
   input  logic signed [ACC_W-1:0] acc_i,
   input  logic signed [ACC_W-1:0] add_i,
   output logic signed [ACC_W-1:0] sum_o,
   output logic                    ovf_o
);

   logic signed [ACC_W-1:0] raw;

   assign raw   = acc_i + add_i;
   assign ovf_o = (acc_i[ACC_W-1] == add_i[ACC_W-1]) &&
                  (raw[ACC_W-1]   != acc_i[ACC_W-1]);

`ifdef S_CSKA_ACC_SAT_EN
   localparam logic signed [ACC_W-1:0] MAXV = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] MINV = {1'b1, {(ACC_W-1){1'b0}}};

   // Both addends share a sign on overflow, so acc's sign picks the rail.
   assign sum_o = ovf_o ? (acc_i[ACC_W-1] ? MINV : MAXV) : raw;
`else
   assign sum_o = raw;
`endif

endmodule

// File: rtl/s_cska_acc_stage.sv
// Registered burst accumulator behind the signed carry-skip adder.
// Build option S_CSKA_ACC_SAT_EN selects saturating accumulation (see s_cska_acc_add).
module s_cska_acc_stage
   import s_cska_pkg::*;
#(
   parameter int N     = 4,
   parameter int ACC_W = 12,
   parameter int BURST = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clear,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [N:0]       in_sum,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [ACC_W-1:0] out_acc,
   output logic                    out_ovf
);

   localparam int CNT_W = (clog2(BURST) < 1) ? 1 : clog2(BURST);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST - 1);

   state_e                  state_q, state_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    ovf_q, ovf_d;

   logic signed [ACC_W-1:0] ext, add_sum;
   logic                    add_ovf;

   assign ext = ACC_W'(in_sum);

   s_cska_acc_add #(.ACC_W(ACC_W)) u_add (
      .acc_i (acc_q),
      .add_i (ext),
      .sum_o (add_sum),
      .ovf_o (add_ovf)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ACCUM;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      // clear wins over any same-cycle accept or handoff.
      if (clear) begin
         state_d = ACCUM;
         acc_d   = '0;
         cnt_d   = '0;
         ovf_d   = 1'b0;
      end else begin
         unique case (state_q)
            ACCUM: begin
               if (in_valid) begin
                  acc_d = add_sum;
                  ovf_d = ovf_q | add_ovf;
                  if (cnt_q == LAST) begin
                     cnt_d   = '0;
                     state_d = HOLD;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state_d = ACCUM;
                  acc_d   = '0;
                  cnt_d   = '0;
                  ovf_d   = 1'b0;
               end
            end
            default: state_d = ACCUM;
         endcase
      end
   end

   assign in_ready  = (state_q == ACCUM);
   assign out_valid = (state_q == HOLD);
   assign out_acc   = acc_q;
   assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_s_cska_acc_stage.sv
// Directed bench: three stage instances (default, ACC_W=6, BURST=1) share clock,
// reset and data; in_valid is steered to one instance at a time.
module tb_s_cska_acc_stage;

   logic        clk = 1'b0;
   logic        rst, clear, in_valid, out_ready;
   logic [4:0]  in_sum;
   int          sel;
   logic [2:0]  iv, ir, ov, of;
   logic [11:0] acc0, acc2;
   logic [5:0]  acc1;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   assign iv[0] = in_valid && (sel == 0);
   assign iv[1] = in_valid && (sel == 1);
   assign iv[2] = in_valid && (sel == 2);

   s_cska_acc_stage #(.N(4), .ACC_W(12), .BURST(8)) u_def (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(iv[0]), .in_ready(ir[0]),
      .in_sum(in_sum), .out_valid(ov[0]), .out_ready(out_ready),
      .out_acc(acc0), .out_ovf(of[0]));

   s_cska_acc_stage #(.N(4), .ACC_W(6), .BURST(8)) u_w6 (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(iv[1]), .in_ready(ir[1]),
      .in_sum(in_sum), .out_valid(ov[1]), .out_ready(out_ready),
      .out_acc(acc1), .out_ovf(of[1]));

   s_cska_acc_stage #(.N(4), .ACC_W(12), .BURST(1)) u_b1 (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(iv[2]), .in_ready(ir[2]),
      .in_sum(in_sum), .out_valid(ov[2]), .out_ready(out_ready),
      .out_acc(acc2), .out_ovf(of[2]));

   typedef struct {
      int sel;
      int val;
      int n;
      int exp_acc;
      int exp_ovf;
   } vec_t;

   vec_t tbl[8];

   function automatic int acc_of(input int s);
      case (s)
         1:       return int'($signed(acc1));
         2:       return int'($signed(acc2));
         default: return int'($signed(acc0));
      endcase
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called a little after a rising edge; reset pulse stays clear of edges.
   task automatic do_reset();
      in_valid = 1'b0;
      clear    = 1'b0;
      rst      = 1'b1;
      #2;
      rst      = 1'b0;
      tick();
   endtask

   task automatic feed(input int s, input int v, input int n);
      sel = s;
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_sum   = 5'(v);
         tick();
      end
      in_valid = 1'b0;
   endtask

   initial begin
      tbl[0] = '{0,   3, 8,   24, 0};
      tbl[1] = '{0,  -1, 8,   -8, 0};
      tbl[2] = '{0,  15, 8,  120, 0};
      tbl[3] = '{0, -16, 8, -128, 0};
`ifdef S_CSKA_ACC_SAT_EN
      tbl[4] = '{1,  15, 8,   31, 1};
      tbl[5] = '{1, -16, 8,  -32, 1};
`else
      tbl[4] = '{1,  15, 8,   -8, 1};
      tbl[5] = '{1, -16, 8,    0, 1};
`endif
      tbl[6] = '{2,   5, 1,    5, 0};
      tbl[7] = '{2,  -7, 1,   -7, 0};

      rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_sum = '0; sel = 0;
      #12;
      rst = 1'b0;
      tick();

      // Reset state
      chk("rst_out_valid", int'(ov[0]), 0);
      chk("rst_in_ready",  int'(ir[0]), 1);
      chk("rst_out_acc",   acc_of(0),   0);
      chk("rst_out_ovf",   int'(of[0]), 0);

      // Table of whole bursts
      for (int k = 0; k < 8; k++) begin
         do_reset();
         out_ready = 1'b1;
         feed(tbl[k].sel, tbl[k].val, tbl[k].n);
         chk($sformatf("tbl%0d_valid", k), int'(ov[tbl[k].sel]), 1);
         if (ov[tbl[k].sel]) begin
            chk($sformatf("tbl%0d_acc", k), acc_of(tbl[k].sel), tbl[k].exp_acc);
            chk($sformatf("tbl%0d_ovf", k), int'(of[tbl[k].sel]), tbl[k].exp_ovf);
         end
         tick();
      end

      // One-cycle latency and a single-cycle in_ready bubble
      do_reset();
      out_ready = 1'b1;
      feed(0, 3, 8);
      chk("lat_valid",     int'(ov[0]), 1);
      chk("lat_ready_low", int'(ir[0]), 0);
      tick();
      chk("lat_ready_back", int'(ir[0]), 1);
      chk("lat_valid_drop", int'(ov[0]), 0);

      // Alternating extremes with gaps, consumer stalled five cycles
      do_reset();
      out_ready = 1'b0;
      sel = 0;
      for (int i = 0; i < 8; i++) begin
         if (i % 3 == 1) begin
            in_valid = 1'b0;
            tick();
         end
         in_valid = 1'b1;
         in_sum   = (i % 2 == 0) ? 5'd15 : 5'b10000;
         tick();
      end
      in_valid = 1'b1;
      in_sum   = 5'd1;
      for (int c = 0; c < 5; c++) begin
         chk("stall_valid", int'(ov[0]), 1);
         chk("stall_ready", int'(ir[0]), 0);
         chk("stall_acc",   acc_of(0),   -4);
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("stall_acc_last", acc_of(0), -4);
      tick();
      chk("handoff_valid", int'(ov[0]), 0);
      chk("handoff_ready", int'(ir[0]), 1);
      feed(0, 1, 8);
      chk("after_stall_acc", acc_of(0), 8);

      // clear mid-burst, with a sample offered in the same cycle
      do_reset();
      out_ready = 1'b1;
      feed(0, 2, 5);
      clear = 1'b1; in_valid = 1'b1; in_sum = 5'd2;
      tick();
      clear = 1'b0; in_valid = 1'b0;
      chk("clear_valid", int'(ov[0]), 0);
      chk("clear_acc",   acc_of(0),   0);
      feed(0, 1, 8);
      chk("clear_burst_valid", int'(ov[0]), 1);
      if (ov[0]) begin
         chk("clear_burst_acc", acc_of(0),   8);
         chk("clear_burst_ovf", int'(of[0]), 0);
      end
      tick();

      // Asynchronous reset while holding a result
      do_reset();
      out_ready = 1'b0;
      feed(0, 3, 8);
      chk("hold_before_rst", int'(ov[0]), 1);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_valid", int'(ov[0]), 0);
      chk("async_rst_acc",   acc_of(0),   0);
      chk("async_rst_ready", int'(ir[0]), 1);
      #1;
      rst = 1'b0;
      tick();
      feed(0, -1, 8);
      chk("post_rst_valid", int'(ov[0]), 1);
      if (ov[0]) chk("post_rst_acc", acc_of(0), -8);
      out_ready = 1'b1;
      tick();

      // BURST=1 with in_valid held: one result every two cycles
      do_reset();
      out_ready = 1'b1;
      sel = 2;
      in_valid = 1'b1;
      in_sum   = 5'd5;
      tick();
      chk("b1_first_valid", int'(ov[2]), 1);
      if (ov[2]) chk("b1_first_acc", acc_of(2), 5);
      in_sum = 5'b11001;
      tick();
      chk("b1_bubble_valid", int'(ov[2]), 0);
      chk("b1_bubble_ready", int'(ir[2]), 1);
      tick();
      in_valid = 1'b0;
      chk("b1_second_valid", int'(ov[2]), 1);
      if (ov[2]) chk("b1_second_acc", acc_of(2), -7);
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
